expr_eval_ctrl: RTL and testbench
=================================

EXPR_EVAL_CTRL -- requirements
Module: expr_eval_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, bit width of the sum, term and result registers (legal range 8..32).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  an ASCII character is present on in.
REQ-005 Port: in_ready  output  1  block accepts a character this cycle.
REQ-006 Port: in  input  8  ASCII character.
REQ-007 Port: out_valid  output  1  result/err are valid and held.
REQ-008 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-009 Port: result  output  WIDTH  expression value, modulo 2^WIDTH.
REQ-010 Port: err  output  1  expression was malformed (or overflowed, see Configuration).

Function
REQ-011 Grammar SHALL be: digit ( op digit )* '=', with digit "0".."9", op "+" or "*", and '=' as the terminator; each operand is exactly one digit.
REQ-012 A character SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; no other cycle SHALL change state.
REQ-013 in_ready SHALL be 1 in every state except S_OUT; out_valid SHALL be 1 only in S_OUT.
REQ-014 States: S_NUM (expect digit; entry state), S_OP (expect op or '='), S_ERR (drain to '='), S_OUT (hold result).
REQ-015 S_NUM + digit d: if pend_mul=1 then term <= term*d, else term <= d; go to S_OP.
REQ-016 S_OP + '+': sum <= sum+term, pend_mul <= 0; go to S_NUM.
REQ-017 S_OP + '*': pend_mul <= 1, sum unchanged; go to S_NUM ('*' binds tighter than '+').
REQ-018 S_OP + '=': result <= sum+term, err <= 0; go to S_OUT; result visible on the cycle after acceptance.
REQ-019 S_NUM + '=' (empty expression or trailing op): result <= 0, err <= 1; go to S_OUT.
REQ-020 Any other character in S_NUM or S_OP (digit in S_OP, op in S_NUM, any non-grammar byte): go to S_ERR.
REQ-021 S_ERR: every accepted character other than '=' SHALL be discarded; '=' SHALL give result <= 0, err <= 1 and go to S_OUT.
REQ-022 S_OUT: result and err SHALL hold stable while out_ready=0; on out_ready=1, go to S_NUM and clear sum, term and pend_mul in the same edge.
REQ-023 in_valid in S_OUT SHALL be ignored (in_ready=0); a simultaneous in_valid and out_ready in S_OUT SHALL NOT consume the character.
REQ-024 All arithmetic SHALL wrap modulo 2^WIDTH; a digit SHALL be zero-extended to WIDTH before use.
REQ-025 Throughput SHALL be one character per cycle; end-to-end latency from '=' acceptance to out_valid SHALL be 1 cycle.

Reset
REQ-026 clr_n=0 SHALL immediately force state=S_NUM, sum=0, term=0, pend_mul=0, result=0, err=0, and out_valid=0; in_ready SHALL be 1 after release.
REQ-027 Reset asserted mid-expression or in S_OUT SHALL discard all partial or pending results with no output pulse.

Configuration
REQ-028 Macro EXPR_OVF_CHECK_EN: when defined, a sticky ovf flag SHALL be set on any carry out of sum+term or any product term*d of at least 2^WIDTH; '=' in S_OP with ovf=1 SHALL give err=1 with result still equal to the wrapped value; ovf SHALL clear with the registers in REQ-022/REQ-026.
REQ-029 Without EXPR_OVF_CHECK_EN, no overflow logic SHALL exist and wrap SHALL be silent (err=0 for well-formed input).

Verification
REQ-030 Stream "1+2*3=", out_ready=1 -> one out_valid pulse, result=7, err=0, in_ready=1 throughout.
REQ-031 Stream "2*3*4+5=" -> result=29, err=0; then "9=" -> result=9, proving the clear in REQ-022.
REQ-032 Streams "12+3=", "+1=", "1+=" and "=" -> each yields result=0, err=1; characters after the error are drained up to '='.
REQ-033 "3=" with out_ready=0 for 5 cycles while in_valid=1 with "4" -> result=3 held, in_ready=0, "4" not consumed until the cycle after out_ready=1.
REQ-034 Drop clr_n to 0 after "5*" -> out_valid=0; after release, "1=" -> result=1, err=0.
REQ-035 WIDTH=8 with "9*9*9=" -> result=729 mod 256=217; err=1 if EXPR_OVF_CHECK_EN is defined, else err=0.

Source files
------------

// File: rtl/expr_eval_ctrl.sv
// expr_eval_ctrl: streaming evaluator for single-digit ASCII expressions of
// the form digit (op digit)* '=' with op in {'+', '*'}; '*' binds tighter.
// Optional feature macro: EXPR_OVF_CHECK_EN (sticky overflow flag -> err).
module expr_eval_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [1:0] S_NUM = 2'd0;
    localparam logic [1:0] S_OP  = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;
    localparam logic [1:0] S_OUT = 2'd3;

    localparam logic [7:0] C_PLUS = 8'h2B;
    localparam logic [7:0] C_MUL  = 8'h2A;
    localparam logic [7:0] C_EQ   = 8'h3D;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_term;
    logic             r_pend_mul;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic             w_accept;
    logic             w_is_digit;
    logic [WIDTH-1:0] w_digit;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_prod;

    assign w_accept   = in_valid && in_ready;
    assign w_is_digit = (in >= 8'h30) && (in <= 8'h39);
    // Low nibble of '0'..'9' is the digit value.
    assign w_digit    = {{(WIDTH-4){1'b0}}, in[3:0]};

`ifdef EXPR_OVF_CHECK_EN
    logic             r_ovf;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH+3:0] w_prod_ext;
    logic             w_sum_carry;
    logic             w_prod_ovf;

    assign w_sum_ext   = {1'b0, r_sum} + {1'b0, r_term};
    assign w_sum       = w_sum_ext[WIDTH-1:0];
    assign w_sum_carry = w_sum_ext[WIDTH];
    assign w_prod_ext  = {4'b0000, r_term} * {{WIDTH{1'b0}}, in[3:0]};
    assign w_prod      = w_prod_ext[WIDTH-1:0];
    assign w_prod_ovf  = |w_prod_ext[WIDTH+3:WIDTH];
`else
    assign w_sum  = r_sum + r_term;
    assign w_prod = r_term * w_digit;
`endif

    // Character-driven FSM with its datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_NUM;
            r_sum      <= '0;
            r_term     <= '0;
            r_pend_mul <= 1'b0;
            r_result   <= '0;
            r_err      <= 1'b0;
`ifdef EXPR_OVF_CHECK_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_NUM: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            r_term  <= r_pend_mul ? w_prod : w_digit;
`ifdef EXPR_OVF_CHECK_EN
                            if (r_pend_mul && w_prod_ovf) r_ovf <= 1'b1;
`endif
                            r_state <= S_OP;
                        end else if (in == C_EQ) begin
                            // Empty expression or trailing operator.
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= S_OUT;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_OP: begin
                    if (w_accept) begin
                        if (in == C_PLUS) begin
                            r_sum      <= w_sum;
                            r_pend_mul <= 1'b0;
`ifdef EXPR_OVF_CHECK_EN
                            if (w_sum_carry) r_ovf <= 1'b1;
`endif
                            r_state    <= S_NUM;
                        end else if (in == C_MUL) begin
                            r_pend_mul <= 1'b1;
                            r_state    <= S_NUM;
                        end else if (in == C_EQ) begin
                            r_result <= w_sum;
`ifdef EXPR_OVF_CHECK_EN
                            r_err    <= r_ovf | w_sum_carry;
                            if (w_sum_carry) r_ovf <= 1'b1;
`else
                            r_err    <= 1'b0;
`endif
                            r_state  <= S_OUT;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    // Drain everything up to the terminator.
                    if (w_accept && (in == C_EQ)) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_sum      <= '0;
                        r_term     <= '0;
                        r_pend_mul <= 1'b0;
`ifdef EXPR_OVF_CHECK_EN
                        r_ovf      <= 1'b0;
`endif
                        r_state    <= S_NUM;
                    end
                end
                default: r_state <= S_NUM;
            endcase
        end
    end

    assign in_ready  = (r_state != S_OUT);
    assign out_valid = (r_state == S_OUT);
    assign result    = r_result;
    assign err       = r_err;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb_expr_eval_ctrl: table-driven expression vectors plus hand sequences for
// backpressure, idle gaps, mid-stream reset and an 8-bit wrap case.
module tb_expr_eval_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;

    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  in8_ch;
    logic        out8_valid;
    logic        out8_ready;
    logic [7:0]  result8;
    logic        err8;

    int n_pass  = 0;
    int n_total = 0;

`ifdef EXPR_OVF_CHECK_EN
    localparam logic OVF_ERR = 1'b1;
`else
    localparam logic OVF_ERR = 1'b0;
`endif

    typedef struct {
        string       s;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    expr_eval_ctrl #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    expr_eval_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in8_valid),
        .in_ready  (in8_ready),
        .in        (in8_ch),
        .out_valid (out8_valid),
        .out_ready (out8_ready),
        .result    (result8),
        .err       (err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Streams one expression at one char per cycle with out_ready=1 and checks
    // the single-cycle result pulse that follows '='.
    task automatic run_expr(input string s, input logic [15:0] exp_res, input logic exp_err);
        bit early_ok;
        early_ok  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (!in_ready || out_valid) early_ok = 1'b0;
            in_valid = 1'b1;
            in_ch    = s[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_ch    = 8'h00;
        check({s, " ready/no early valid"}, 32'(early_ok), 32'd1);
        check({s, " out_valid"}, 32'(out_valid), 32'd1);
        check({s, " result"}, 32'(result), 32'(exp_res));
        check({s, " err"}, 32'(err), 32'(exp_err));
        check({s, " in_ready low in S_OUT"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({s, " single pulse"}, 32'(out_valid), 32'd0);
        check({s, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{s: "1+2*3=",         res: 16'd7,     err: 1'b0};
        vecs[1]  = '{s: "2*3*4+5=",       res: 16'd29,    err: 1'b0};
        vecs[2]  = '{s: "9=",             res: 16'd9,     err: 1'b0};
        vecs[3]  = '{s: "12+3=",          res: 16'd0,     err: 1'b1};
        vecs[4]  = '{s: "+1=",            res: 16'd0,     err: 1'b1};
        vecs[5]  = '{s: "1+=",            res: 16'd0,     err: 1'b1};
        vecs[6]  = '{s: "=",              res: 16'd0,     err: 1'b1};
        vecs[7]  = '{s: "1a2+3=",         res: 16'd0,     err: 1'b1};
        vecs[8]  = '{s: "0*5+8=",         res: 16'd8,     err: 1'b0};
        vecs[9]  = '{s: "9*9*9*9*9+1=",   res: 16'd59050, err: 1'b0};
        // 5^7 = 78125 wraps to 12589 in 16 bits.
        vecs[10] = '{s: "5*5*5*5*5*5*5=", res: 16'd12589, err: OVF_ERR};
        vecs[11] = '{s: "1++2=",          res: 16'd0,     err: 1'b1};

        clr_n      = 1'b1;
        in_valid   = 1'b0;
        in_ch      = 8'h00;
        out_ready  = 1'b1;
        in8_valid  = 1'b0;
        in8_ch     = 8'h00;
        out8_ready = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset out8_valid", 32'(out8_valid), 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        for (int v = 0; v < 12; v++) run_expr(vecs[v].s, vecs[v].res, vecs[v].err);

        // Idle cycles with garbage on the bus must not change state.
        @(negedge clk); in_valid = 1'b1; in_ch = "1";
        @(negedge clk); in_ch = "+";
        @(negedge clk); in_valid = 1'b0; in_ch = "9";
        repeat (3) @(negedge clk);
        run_expr("2=", 16'd3, 1'b0);

        // Backpressure: result held, "4" waits until S_OUT is left.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_ch = "3";
        @(negedge clk); in_ch = "=";
        @(negedge clk); in_ch = "4";
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp result", 32'(result), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold result", 32'(result), 32'd3);
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp released valid", 32'(out_valid), 32'd0);
        check("bp released ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_ch = "=";
        @(negedge clk); in_valid = 1'b0;
        check("bp 4 consumed once valid", 32'(out_valid), 32'd1);
        check("bp 4 consumed once result", 32'(result), 32'd4);
        check("bp 4 consumed once err", 32'(err), 32'd0);
        @(negedge clk);

        // Reset mid-expression discards the pending "5*".
        @(negedge clk); in_valid = 1'b1; in_ch = "5";
        @(negedge clk); in_ch = "*";
        @(negedge clk); in_valid = 1'b0; clr_n = 1'b0;
        #1 check("mid reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("mid reset no pulse", 32'(out_valid), 32'd0);
        clr_n = 1'b1;
        run_expr("1=", 16'd1, 1'b0);

        // Reset while holding a result in S_OUT.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_ch = "7";
        @(negedge clk); in_ch = "=";
        @(negedge clk); in_valid = 1'b0;
        check("hold before reset", 32'(out_valid), 32'd1);
        clr_n = 1'b0;
        #1;
        check("reset in S_OUT valid", 32'(out_valid), 32'd0);
        check("reset in S_OUT result", 32'(result), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run_expr("2=", 16'd2, 1'b0);

        // 8-bit instance: 729 wraps to 217.
        for (int i = 0; i < 6; i++) begin
            string e8;
            e8 = "9*9*9=";
            @(negedge clk);
            in8_valid = 1'b1;
            in8_ch    = e8[i];
        end
        @(negedge clk);
        in8_valid = 1'b0;
        check("w8 out_valid", 32'(out8_valid), 32'd1);
        check("w8 result", 32'(result8), 32'd217);
        check("w8 err", 32'(err8), 32'(OVF_ERR));
        @(negedge clk);
        check("w8 single pulse", 32'(out8_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
